// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetch: issues program-memory reads, assembles
// BYTES_PER_INSTR bytes little-endian and hands the word to the decoder.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_FETCH | issuing reads and collecting returned bytes
// ST_HOLD  | complete instruction held, waiting for decoder
module instruction_fetch #(
  parameter int ADDR_WIDTH      = 8,
  parameter int BYTE_WIDTH      = 8,
  parameter int BYTES_PER_INSTR = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic                                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  input  logic [BYTE_WIDTH-1:0]                 mem_rdata,
  output logic [BYTE_WIDTH*BYTES_PER_INSTR-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]                 instr_pc,
  output logic                                  instr_valid,
  input  logic                                  instr_ready,
  input  logic                                  jump_en,
  input  logic [ADDR_WIDTH-1:0]                 jump_addr
);

  localparam int CW = $clog2(BYTES_PER_INSTR + 1);
  localparam int IW = BYTE_WIDTH * BYTES_PER_INSTR;
  localparam logic [CW-1:0] NUM  = CW'(BYTES_PER_INSTR);
  localparam logic [CW-1:0] LAST = CW'(BYTES_PER_INSTR - 1);

  typedef enum logic {ST_FETCH = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [CW-1:0]         r_issue_cnt;
  logic [CW-1:0]         r_recv_cnt;
  logic                  r_pend;
  logic [IW-1:0]         r_instr;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic                  r_valid;

  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_done;
  logic                  w_handshake;

  assign w_done      = (r_state == ST_FETCH) && r_pend && (r_recv_cnt == LAST);
  assign w_handshake = r_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (jump_en) begin
      w_state_next = ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: if (w_done)      w_state_next = ST_HOLD;
        ST_HOLD:  if (w_handshake) w_state_next = ST_FETCH;
        default:                   w_state_next = ST_FETCH;
      endcase
    end
  end

  always_comb begin
    w_rd_en = (r_state == ST_FETCH) && (r_issue_cnt < NUM) && !rst;
    w_addr  = r_pc + ADDR_WIDTH'(r_issue_cnt);
  end

  // r_pend tags the byte arriving this cycle as belonging to the current fetch;
  // clearing it on jump/reset drops any read already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_pend      <= 1'b0;
      r_instr     <= '0;
      r_instr_pc  <= '0;
      r_valid     <= 1'b0;
    end else if (jump_en) begin
      r_pc        <= jump_addr;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_pend      <= 1'b0;
      r_valid     <= 1'b0;
    end else if (r_state == ST_FETCH) begin
      r_pend <= w_rd_en;
      if (w_rd_en) r_issue_cnt <= r_issue_cnt + 1'b1;
      if (r_pend) begin
        for (int k = 0; k < BYTES_PER_INSTR; k++) begin
          if (r_recv_cnt == CW'(k)) r_instr[BYTE_WIDTH*k +: BYTE_WIDTH] <= mem_rdata;
        end
        if (r_recv_cnt == LAST) begin
          r_valid     <= 1'b1;
          r_instr_pc  <= r_pc;
          r_pc        <= r_pc + ADDR_WIDTH'(BYTES_PER_INSTR);
          r_issue_cnt <= '0;
          r_recv_cnt  <= '0;
        end else begin
          r_recv_cnt <= r_recv_cnt + 1'b1;
        end
      end
    end else begin
      r_pend <= 1'b0;
      if (w_handshake) r_valid <= 1'b0;
    end
  end

  assign mem_rd_en   = w_rd_en;
  assign mem_addr    = w_addr;
  assign instr_out   = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;

endmodule
